// File: rtl/mult_share_arbiter_if.sv
// Purpose: bundles the requester side and the multiplier side of the shared-multiplier arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until ack; the multiplier signals completion with m_rdy.
interface mult_share_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] op_a;
    logic [8*N_REQ-1:0] op_b;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   ack;
    logic               err;
    logic [15:0]        res;
    logic               busy;
    logic               m_ld;
    logic [7:0]         m_a;
    logic [7:0]         m_b;
    logic               m_rdy;
    logic [15:0]        m_result;

    // Arbiter view.
    modport slave (
        input  req, op_a, op_b, m_rdy, m_result,
        output gnt, ack, err, res, busy, m_ld, m_a, m_b
    );

    // Requesters plus multiplier view.
    modport master (
        output req, op_a, op_b, m_rdy, m_result,
        input  gnt, ack, err, res, busy, m_ld, m_a, m_b
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Purpose: round-robin sharing of one 8x8 multiplier, one transaction at a time, with a watchdog.
// Latency: grant/load 1 cycle after request sample; ack 1 cycle after m_rdy (or after TIMEOUT cycles in WAIT).
// Backpressure: requests wait in IDLE while busy; req must be held until the matching ack pulse.
module mult_share_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    mult_share_arbiter_if.slave     bus
);
    localparam int PW = (N_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win_q;
    logic [7:0]       wd_cnt;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] ack_q;
    logic             err_q;
    logic [15:0]      res_q;
    logic             busy_q;
    logic             m_ld_q;
    logic [7:0]       m_a_q;
    logic [7:0]       m_b_q;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    jj;
    logic [N_REQ-1:0] win_oh;
    int               j;

    // Round-robin search starting at ptr; walking offsets from high to low lets the nearest requester win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        j         = 0;
        jj        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = PW'(j);
            if (bus.req[jj]) begin
                win_found  = 1'b1;
                win_idx    = jj;
                win_oh     = '0;
                win_oh[jj] = 1'b1;
            end
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= '0;
            win_q  <= '0;
            wd_cnt <= '0;
            gnt_q  <= '0;
            ack_q  <= '0;
            err_q  <= 1'b0;
            res_q  <= '0;
            busy_q <= 1'b0;
            m_ld_q <= 1'b0;
            m_a_q  <= '0;
            m_b_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        win_q  <= win_idx;
                        gnt_q  <= win_oh;
                        m_a_q  <= bus.op_a[8*int'(win_idx) +: 8];
                        m_b_q  <= bus.op_b[8*int'(win_idx) +: 8];
                        m_ld_q <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    m_ld_q <= 1'b0;
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    // A ready arriving on the timeout cycle still delivers the real product.
                    if (bus.m_rdy) begin
                        res_q <= bus.m_result;
                        err_q <= 1'b0;
                        ack_q <= gnt_q;
                        state <= DONE;
                    end else if (wd_cnt == 8'(TIMEOUT - 1)) begin
                        res_q <= 16'hFFFF;
                        err_q <= 1'b1;
                        ack_q <= gnt_q;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ack_q  <= '0;
                    err_q  <= 1'b0;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    ptr    <= (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.ack  = ack_q;
    assign bus.err  = err_q;
    assign bus.res  = res_q;
    assign bus.busy = busy_q;
    assign bus.m_ld = m_ld_q;
    assign bus.m_a  = m_a_q;
    assign bus.m_b  = m_b_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Purpose: self-checking bench for mult_share_arbiter with a latency-programmable multiplier model.
// Latency: transactions are checked cycle-exactly against the request sample cycle.
// Backpressure: requesters hold req until ack and drop it in the following cycle.
module tb_mult_share_arbiter;
    localparam int N = 2;
    localparam int T = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.N_REQ(N)) bus_i ();
    mult_share_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    int checks   = 0;
    int errors   = 0;
    int lat      = 3;
    int rem      = 0;
    int cyc      = 0;
    int spur_cyc = -1;
    int mptr     = 0;

    typedef struct {
        logic [1:0]  rq;
        logic [7:0]  a0, b0, a1, b1;
        int          l;
        logic [1:0]  eg;
        logic [15:0] eres;
        logic        ee;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Multiplier model: m_rdy fires lat cycles after the load cycle (lat=0 never answers).
    always @(negedge clk) begin
        cyc++;
        bus_i.m_rdy    = 1'b0;
        bus_i.m_result = 16'h0;
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                bus_i.m_rdy    = 1'b1;
                bus_i.m_result = 16'(bus_i.m_a) * 16'(bus_i.m_b);
            end
        end
        if (cyc == spur_cyc) begin
            bus_i.m_rdy    = 1'b1;
            bus_i.m_result = 16'h1234;
        end
        if (bus_i.m_ld) rem = lat;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, " gnt"},  32'(bus_i.gnt),  32'd0);
        check({tag, " ack"},  32'(bus_i.ack),  32'd0);
        check({tag, " err"},  32'(bus_i.err),  32'd0);
        check({tag, " res"},  32'(bus_i.res),  32'd0);
        check({tag, " busy"}, 32'(bus_i.busy), 32'd0);
        check({tag, " m_ld"}, 32'(bus_i.m_ld), 32'd0);
        check({tag, " m_a"},  32'(bus_i.m_a),  32'd0);
        check({tag, " m_b"},  32'(bus_i.m_b),  32'd0);
    endtask

    // Drive one request set from an IDLE cycle and check the whole transaction.
    task automatic run_txn(input string tag, input logic [1:0] rq,
                           input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1,
                           input int l, input bit mut,
                           input logic [1:0] eg, input logic [15:0] eres, input logic ee);
        int n;
        int expn;
        logic [7:0] ea;
        logic [7:0] eb;
        ea   = eg[1] ? a1 : a0;
        eb   = eg[1] ? b1 : b0;
        expn = 2 + ((l == 0 || l > T) ? T : l);
        lat  = l;
        bus_i.req  = rq;
        bus_i.op_a = {a1, a0};
        bus_i.op_b = {b1, b0};
        @(negedge clk);
        check({tag, " gnt@load"},  32'(bus_i.gnt),  32'(eg));
        check({tag, " m_ld@load"}, 32'(bus_i.m_ld), 32'd1);
        check({tag, " m_a"},       32'(bus_i.m_a),  32'(ea));
        check({tag, " m_b"},       32'(bus_i.m_b),  32'(eb));
        check({tag, " busy@load"}, 32'(bus_i.busy), 32'd1);
        n = 1;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                check({tag, " m_ld@wait"}, 32'(bus_i.m_ld), 32'd0);
                if (mut) bus_i.op_a = {8'd5, 8'd5};
            end
            if (n == 3 && mut) check({tag, " m_a held"}, 32'(bus_i.m_a), 32'(ea));
        end while (bus_i.ack == '0 && n < 40);
        check({tag, " ack latency"}, 32'(n), 32'(expn));
        check({tag, " ack"},         32'(bus_i.ack), 32'(eg));
        check({tag, " err"},         32'(bus_i.err), 32'(ee));
        check({tag, " res"},         32'(bus_i.res), 32'(eres));
        check({tag, " gnt@done"},    32'(bus_i.gnt), 32'(eg));
        bus_i.req = '0;
        @(negedge clk);
        check({tag, " ack@idle"},  32'(bus_i.ack),  32'd0);
        check({tag, " err@idle"},  32'(bus_i.err),  32'd0);
        check({tag, " gnt@idle"},  32'(bus_i.gnt),  32'd0);
        check({tag, " busy@idle"}, 32'(bus_i.busy), 32'd0);
        check({tag, " res held"},  32'(bus_i.res),  32'(eres));
        mptr = eg[1] ? 0 : 1;
    endtask

    initial begin
        logic [1:0]  mask;
        logic [7:0]  ra0, rb0, ra1, rb1;
        logic [1:0]  eg;
        logic [15:0] eres;
        int          l;
        int          w;
        int          jx;

        tbl[0] = '{2'b11, 8'd3,   8'd4,   8'd5,   8'd6,   2, 2'b01, 16'd12,    1'b0};
        tbl[1] = '{2'b11, 8'd3,   8'd4,   8'd5,   8'd6,   2, 2'b10, 16'd30,    1'b0};
        tbl[2] = '{2'b11, 8'd3,   8'd4,   8'd5,   8'd6,   2, 2'b01, 16'd12,    1'b0};
        tbl[3] = '{2'b11, 8'd3,   8'd4,   8'd5,   8'd6,   2, 2'b10, 16'd30,    1'b0};
        tbl[4] = '{2'b01, 8'd200, 8'd150, 8'd0,   8'd0,   3, 2'b01, 16'd30000, 1'b0};
        tbl[5] = '{2'b01, 8'd9,   8'd9,   8'd0,   8'd0,   0, 2'b01, 16'hFFFF,  1'b1};
        tbl[6] = '{2'b10, 8'd0,   8'd0,   8'd255, 8'd255, 8, 2'b10, 16'd65025, 1'b0};
        tbl[7] = '{2'b01, 8'd7,   8'd7,   8'd0,   8'd0,   9, 2'b01, 16'hFFFF,  1'b1};
        tbl[8] = '{2'b11, 8'd2,   8'd3,   8'd4,   8'd5,   1, 2'b10, 16'd20,    1'b0};
        tbl[9] = '{2'b10, 8'd0,   8'd0,   8'd16,  8'd16,  5, 2'b10, 16'd256,   1'b0};

        bus_i.req  = '0;
        bus_i.op_a = '0;
        bus_i.op_b = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].rq, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
                    tbl[i].l, 1'b0, tbl[i].eg, tbl[i].eres, tbl[i].ee);
        end

        run_txn("opstab", 2'b01, 8'd10, 8'd10, 8'd0, 8'd0, 4, 1'b1, 2'b01, 16'd100, 1'b0);

        spur_cyc = cyc + 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("spur ack", 32'(bus_i.ack), 32'd0);
        end
        check("spur res", 32'(bus_i.res), 32'd100);
        run_txn("spur txn", 2'b10, 8'd0, 8'd0, 8'd255, 8'd255, 2, 1'b0, 2'b10, 16'd65025, 1'b0);

        for (int i = 0; i < 20; i++) begin
            mask = 2'($urandom_range(1, 3));
            ra0  = 8'($urandom);
            rb0  = 8'($urandom);
            ra1  = 8'($urandom);
            rb1  = 8'($urandom);
            l    = $urandom_range(0, 10);
            w    = -1;
            for (int k = 0; k < N; k++) begin
                jx = (mptr + k) % N;
                if (mask[jx] && w < 0) w = jx;
            end
            eg = (w == 1) ? 2'b10 : 2'b01;
            if (l >= 1 && l <= T) eres = (w == 1) ? 16'(ra1) * 16'(rb1) : 16'(ra0) * 16'(rb0);
            else                  eres = 16'hFFFF;
            run_txn($sformatf("rand%0d", i), mask, ra0, rb0, ra1, rb1, l, 1'b0, eg, eres,
                    (l >= 1 && l <= T) ? 1'b0 : 1'b1);
        end

        lat        = 0;
        bus_i.req  = 2'b01;
        bus_i.op_a = {8'd0, 8'd3};
        bus_i.op_b = {8'd0, 8'd3};
        repeat (3) @(negedge clk);
        check("midrst busy before", 32'(bus_i.busy), 32'd1);
        reset     = 1'b0;
        bus_i.req = '0;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst no ack", 32'(bus_i.ack), 32'd0);
        end
        mptr = 0;
        run_txn("post rst", 2'b11, 8'd6, 8'd7, 8'd8, 8'd9, 2, 1'b0, 2'b01, 16'd42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter that shares the single 8x8 multiplier between several requesters, such as the color wheel processor and a brightness/fade scaler. It sits between the requesters and the multiplier's `ld`/`a`/`b`/`mult_rdy`/`result` port. It serialises one multiplication at a time, latches operands and result, and returns a one-cycle acknowledge to the owner. A watchdog aborts a transaction if the multiplier never signals ready.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, range 2..4.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before abort, range 4..255.

Ports:
- `clk`, in, 1: system clock, the same clock used by the multiplier.
- `reset`, in, 1: synchronous, active-low reset.
- `req`, in, N_REQ: per-requester request level, held until its `ack` bit is seen.
- `op_a`, in, 8*N_REQ: packed multiplicand A; requester i uses bits [8i+7:8i]. Stable while `req[i]` is high.
- `op_b`, in, 8*N_REQ: packed multiplicand B, same packing.
- `gnt`, out, N_REQ: one-hot owner of the multiplier, zero when idle.
- `ack`, out, N_REQ: one-hot, one-cycle completion pulse.
- `err`, out, 1: pulses together with `ack` when the transaction was aborted by timeout.
- `res`, out, 16: result of the last transaction, held until the next completion.
- `busy`, out, 1: high in every state except IDLE.
- `m_ld`, out, 1: load strobe to the multiplier.
- `m_a`, out, 8: registered operand A to the multiplier.
- `m_b`, out, 8: registered operand B to the multiplier.
- `m_rdy`, in, 1: multiplier result-valid.
- `m_result`, in, 16: multiplier product.

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE. All outputs are registered.
- IDLE
  - If any `req` bit is high, select the winner by round robin, starting the search at `ptr` (the index after the last winner) and wrapping modulo N_REQ.
  - Latch the winner's operands into `m_a`/`m_b`, set `gnt` one-hot, go to LOAD.
  - If no `req` bit is high, stay in IDLE; `gnt`=0.
- LOAD
  - `m_ld`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT
  - `m_ld`=0; the watchdog counter increments every cycle.
  - If `m_rdy`=1: `res`<=`m_result`, `err` flag<=0, go to DONE.
  - Otherwise, if the counter reaches TIMEOUT-1: `res`<=16'hFFFF, `err` flag<=1, go to DONE.
  - If `m_rdy` and timeout occur in the same cycle, `m_rdy` wins.
- DONE
  - `ack[winner]`=1 and `err`=flag, both for exactly this cycle.
  - `ptr`<=winner+1 mod N_REQ; clear `gnt`; go to IDLE.
- `m_rdy` is ignored in IDLE, LOAD and DONE.
- Dropping `req[winner]` mid-transaction does not cancel it; the transaction completes and `ack` is still pulsed.
- Requesters deassert `req` on the cycle after `ack`. A `req` still high in the IDLE cycle that follows is treated as a new request. Round robin prevents starvation: with all requesters active, each one is served within N_REQ transactions.
- Operands are sampled only in IDLE; later changes on `op_a`/`op_b` do not affect an in-flight multiplication.
- Reset values (`reset`=0 at a clock edge): state=IDLE, `ptr`=0, watchdog counter=0, `gnt`=0, `ack`=0, `err`=0, `res`=0, `busy`=0, `m_ld`=0, `m_a`=0, `m_b`=0.
- Reset asserted in any state aborts the transaction immediately, with no `ack` pulse.

## Timing
- Cycle t: IDLE samples `req`.
- Cycle t+1: LOAD; `gnt`, `m_a` and `m_b` are valid and `m_ld`=1.
- If the multiplier raises `m_rdy` in cycle t+1+L, then `ack`/`res` are valid in cycle t+2+L.
- The earliest next arbitration is in cycle t+3+L, so throughput is one multiplication per L+3 cycles.
- Timeout path: `ack` with `err`=1 arrives in cycle t+2+TIMEOUT.
- `busy` is high from t+1 through the DONE cycle inclusive.
- `gnt` stays stable from LOAD through the DONE cycle and is 0 in IDLE.

## Test plan
- **Single request.** N_REQ=2; `req`=01, `op_a[7:0]`=8'd200, `op_b[7:0]`=8'd150; model returns `m_rdy` 3 cycles after `m_ld`. Required: `m_ld` pulse with `m_a`=200, `m_b`=150; `ack`=01 for one cycle; `res`=16'd30000; `err`=0.
- **Round robin.** `req`=11 held, reassert after each `ack`. Required: grants alternate 01,10,01,10; `ptr` reset to 0 makes the first grant go to requester 0.
- **Timeout.** TIMEOUT=8, `m_rdy` held at 0. Required: `ack`=01 and `err`=1 exactly 10 cycles after the request is sampled; `res`=16'hFFFF; next request is served normally.
- **Operand stability.** Change `op_a` to 8'd5 during WAIT (original 8'd10, `op_b`=8'd10). Required: `m_a` stays 10; `res`=16'd100.
- **Spurious ready.** Pulse `m_rdy` while IDLE, then issue `req`=10 with 8'd255×8'd255. Required: no `ack` from the stray pulse; `res`=16'd65025.
- **Reset mid-operation.** Assert `reset`=0 during WAIT. Required: next cycle all outputs are at their reset values, no `ack` pulse, and the FSM accepts a new request after release.
